// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder controller
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_add_state_t;

    localparam int SERIAL_ADD_WIDTH_DEF = 8;

    // Bit counter width; a single-bit operand still needs a one-bit counter.
    function automatic int serial_add_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operand/result handshake bundle; optional sub via SERIAL_ADD_SUB_EN
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::SERIAL_ADD_WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit combinational full adder cell
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_cin;
    assign o_c = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencing one full_adder LSB-first; SERIAL_ADD_SUB_EN adds A-B
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    bus
);

    localparam int                CNT_W    = serial_add_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    serial_add_state_t  r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;
    logic [WIDTH-1:0]   w_sum_next;

    // Subtraction is A + ~B + 1, so the carry-in is forced and cout reads as "no borrow".
`ifdef SERIAL_ADD_SUB_EN
    assign w_b_load = bus.sub ? ~bus.b : bus.b;
    assign w_c_load = bus.sub ? 1'b1 : bus.cin;
`else
    assign w_b_load = bus.b;
    assign w_c_load = bus.cin;
`endif

    always_comb begin
        w_sum_next            = r_sum_sr >> 1;
        w_sum_next[WIDTH-1]   = w_s;
    end

    full_adder u_full_adder (
        .i_a   (r_a_sr[0]),
        .i_b   (r_b_sr[0]),
        .i_cin (r_carry),
        .o_s   (w_s),
        .o_c   (w_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_sum_sr    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_a_sr     <= bus.a;
                        r_b_sr     <= w_b_load;
                        r_carry    <= w_c_load;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_c;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready goes high on the same edge so the IDLE cycle can accept.
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum_sr;
    assign bus.cout      = r_carry;

endmodule
